// File: rtl/bcd_stopwatch_counter.sv
// Stopwatch timebase: divides clk to a 1 ms tick and drives a five-digit BCD count 00.000..59.999
// with start/stop/clear control and a lap-hold snapshot of the displayed value.
module bcd_stopwatch_counter #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned N        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start_stop,
  input  logic         btn_clear,
  input  logic         lap_hold,
  output logic [N-1:0] count,
  output logic [N-1:0] dec,
  output logic [N-1:0] cent,
  output logic [N-1:0] seg,
  output logic [N-1:0] seg_dec,
  output logic         running,
  output logic         wrap
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV >= 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : gen_div_check
    $error("bcd_stopwatch_counter: CLK_FREQ/TICK_HZ must be >= 2");
  end
  if (N < 4) begin : gen_width_check
    $error("bcd_stopwatch_counter: N must be >= 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  // Synchronizer shift registers: bit 0 metastable stage, bit 1 synced, bit 2 previous synced.
  logic [2:0]      ss_q, ss_d;
  logic [2:0]      clr_q, clr_d;
  logic [2:0]      lap_q, lap_d;
  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [4:0][3:0] dig_q, dig_d;
  logic [4:0][3:0] snap_q, snap_d;
  logic            hold_q, hold_d;
  logic            running_q, running_d;
  logic            wrap_q, wrap_d;

  logic            start_p, clear_p, lap_rise, tick, at_max, carry;
  logic [3:0]      lim;
  logic [4:0][3:0] disp;

  always_comb begin
    ss_d     = {ss_q[1:0], btn_start_stop};
    clr_d    = {clr_q[1:0], btn_clear};
    lap_d    = {lap_q[1:0], lap_hold};
    start_p  = ss_q[1] & ~ss_q[2];
    clear_p  = clr_q[1] & ~clr_q[2];
    lap_rise = lap_q[1] & ~lap_q[2];
    hold_d   = lap_q[1];

    tick   = (state_q == StRun) && (presc_q == PW'(DIV - 1));
    at_max = (dig_q == 20'h59999);

    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;
    snap_d  = snap_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    lim     = 4'd9;

    if (tick) begin
      presc_d = '0;
      wrap_d  = at_max;
      for (int i = 0; i < 5; i++) begin
        lim = (i == 4) ? 4'd5 : 4'd9;
        if (carry) begin
          if (dig_q[i] >= lim) begin
            dig_d[i] = 4'd0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end else if (state_q == StRun) begin
      presc_d = presc_q + PW'(1);
    end

    if (lap_rise) begin
      snap_d = dig_q;
    end

    // Clear overrides everything, including a simultaneous start or lap capture.
    if (clear_p) begin
      state_d = StIdle;
      presc_d = '0;
      dig_d   = '0;
      snap_d  = '0;
      wrap_d  = 1'b0;
    end else if (start_p) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q      <= '0;
      clr_q     <= '0;
      lap_q     <= '0;
      state_q   <= StIdle;
      presc_q   <= '0;
      dig_q     <= '0;
      snap_q    <= '0;
      hold_q    <= 1'b0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      ss_q      <= ss_d;
      clr_q     <= clr_d;
      lap_q     <= lap_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      dig_q     <= dig_d;
      snap_q    <= snap_d;
      hold_q    <= hold_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    disp    = hold_q ? snap_q : dig_q;
    count   = N'(disp[0]);
    dec     = N'(disp[1]);
    cent    = N'(disp[2]);
    seg     = N'(disp[3]);
    seg_dec = N'(disp[4]);
    running = running_q;
    wrap    = wrap_q;
  end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Randomized and directed bench for bcd_stopwatch_counter against a millisecond-integer model.
module tb_bcd_stopwatch_counter;

  localparam int unsigned CLK_FREQ = 4000;
  localparam int unsigned TICK_HZ  = 1000;
  localparam int unsigned N        = 5;
  localparam int          DIV      = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         btn_ss = 1'b0;
  logic         btn_clr = 1'b0;
  logic         lap = 1'b0;
  logic [N-1:0] count, dec, cent, seg, seg_dec;
  logic         running, wrap;

  bcd_stopwatch_counter #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ),
    .N       (N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_stop(btn_ss),
    .btn_clear     (btn_clr),
    .lap_hold      (lap),
    .count         (count),
    .dec           (dec),
    .cent          (cent),
    .seg           (seg),
    .seg_dec       (seg_dec),
    .running       (running),
    .wrap          (wrap)
  );

  always #5 clk = ~clk;

  // Model: time kept as an integer number of ms; 0=idle, 1=run, 2=pause.
  int       m_state = 0, m_ps = 0, m_ms = 0, m_snap = 0;
  bit       m_hold = 0, m_wrap = 0;
  bit [2:0] ss_h = '0, clr_h = '0, lap_h = '0;
  int       preload_seq = 0, preload_seen = 0, preload_val = 0;

  int       tests = 0, fails = 0;
  int       lit_seq = 0, lit_done = 0, lit_lo = 0, lit_hi = 0, lit_kind = 0;
  bit       lit_run = 0, lit_wrap = 0;
  string    lit_name = "";
  logic [19:0] pre_bcd;

  function automatic logic [19:0] to_bcd(input int v);
    return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10),
            4'(v % 10)};
  endfunction

  initial begin : model
    bit start, clr, lrise, tick, nwrap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_ps = 0; m_ms = 0; m_snap = 0; m_hold = 0; m_wrap = 0;
        ss_h = '0; clr_h = '0; lap_h = '0;
      end else begin
        if (preload_seq != preload_seen) begin
          m_ms = preload_val;
          preload_seen = preload_seq;
        end
        // Inputs act two edges after they are sampled.
        start = ss_h[1] && !ss_h[2];
        clr   = clr_h[1] && !clr_h[2];
        lrise = lap_h[1] && !lap_h[2];
        tick  = (m_state == 1) && (m_ps == DIV - 1);
        nwrap = 0;
        if (lrise) m_snap = m_ms;
        m_hold = lap_h[1];
        if (tick) begin
          nwrap = (m_ms == 59999);
          m_ms  = (m_ms + 1) % 60000;
          m_ps  = 0;
        end else if (m_state == 1) begin
          m_ps = m_ps + 1;
        end
        if (clr) begin
          m_state = 0; m_ms = 0; m_ps = 0; m_snap = 0; nwrap = 0;
        end else if (start) begin
          m_state = (m_state == 1) ? 2 : 1;
        end
        m_wrap = nwrap;
        ss_h  = {ss_h[1:0], btn_ss};
        clr_h = {clr_h[1:0], btn_clr};
        lap_h = {lap_h[1:0], lap};
      end
    end
  end

  initial begin : compare
    int e, got;
    forever begin
      @(negedge clk);
      #1;
      e = m_hold ? m_snap : m_ms;
      tests++;
      if (count !== N'(e % 10) || dec !== N'((e / 10) % 10) || cent !== N'((e / 100) % 10) ||
          seg !== N'((e / 1000) % 10) || seg_dec !== N'(e / 10000) ||
          running !== (m_state == 1) || wrap !== m_wrap) begin
        fails++;
        $display("FAIL cycle t=%0t: got %0d%0d.%0d%0d%0d run=%b wrap=%b, expected %05d run=%0d wrap=%0d",
                 $time, seg_dec, seg, cent, dec, count, running, wrap, e, m_state == 1, m_wrap);
      end
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        tests++;
        got = int'(seg_dec) * 10000 + int'(seg) * 1000 + int'(cent) * 100 + int'(dec) * 10 +
              int'(count);
        if (lit_kind == 1) begin
          fails++;
          $display("FAIL %s: bound expired, got %0d, expected event", lit_name, got);
        end else if (got < lit_lo || got > lit_hi || running !== lit_run || wrap !== lit_wrap) begin
          fails++;
          $display("FAIL %s: got %0d run=%b wrap=%b, expected %0d..%0d run=%0d wrap=%0d",
                   lit_name, got, running, wrap, lit_lo, lit_hi, lit_run, lit_wrap);
        end
      end
    end
  end

  task automatic expect_lit(input int lo, input int hi, input bit run, input bit wr,
                            input string name);
    lit_lo = lo; lit_hi = hi; lit_run = run; lit_wrap = wr; lit_name = name; lit_kind = 0;
    lit_seq++;
    wait (lit_done == lit_seq);
  endtask

  task automatic expect_timeout(input string name);
    lit_name = name; lit_kind = 1;
    lit_seq++;
    wait (lit_done == lit_seq);
  endtask

  task automatic press(input bit s, input bit c);
    @(negedge clk);
    btn_ss = s; btn_clr = c;
    @(negedge clk);
    btn_ss = 1'b0; btn_clr = 1'b0;
  endtask

  // Loads the live digits between a compare point and the next active edge.
  task automatic preload(input int v);
    @(negedge clk);
    #2;
    pre_bcd = to_bcd(v);
    force dut.dig_q = pre_bcd;
    #1;
    release dut.dig_q;
    preload_val = v;
    preload_seq++;
  endtask

  // Waits (at posedge+2) for seg_dec==want_sd or wrap; returns found flag.
  task automatic wait_event(input bit on_wrap, input int want_sd, output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #2;
      if (on_wrap ? (wrap === 1'b1) : (int'(seg_dec) == want_sd)) found = 1;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    bit found;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_lit(0, 0, 0, 0, "reset_state");
    rst_n = 1'b1;

    // Basic count: RUN two edges after the press, one ms per DIV clocks.
    press(1, 0);
    repeat (2) @(negedge clk);
    expect_lit(0, 0, 1, 0, "run_entered");
    repeat (40) @(negedge clk);
    expect_lit(10, 10, 1, 0, "count_10ms");

    // Pause at 00.007 with prescaler 2, resume keeps the phase.
    press(0, 1);
    press(1, 0);
    repeat (28) @(negedge clk);
    press(1, 0);
    repeat (100) @(negedge clk);
    expect_lit(7, 7, 0, 0, "pause_hold");
    press(1, 0);
    repeat (3) @(negedge clk);
    expect_lit(7, 7, 1, 0, "resume_pre_tick");
    @(negedge clk);
    expect_lit(8, 8, 1, 0, "resume_tick");

    // Clear and start together: clear wins.
    preload(123);
    press(1, 1);
    repeat (2) @(negedge clk);
    expect_lit(0, 0, 0, 0, "clear_priority");
    press(1, 0);
    repeat (2) @(negedge clk);
    expect_lit(0, 0, 1, 0, "restart_zero");

    // Carry chain and wrap.
    preload(9999);
    wait_event(0, 1, found);
    if (found) expect_lit(10000, 10000, 1, 0, "carry_10s");
    else expect_timeout("carry_10s");
    preload(59999);
    wait_event(1, 0, found);
    if (found) begin
      expect_lit(0, 0, 1, 1, "wrap_pulse");
      expect_lit(0, 0, 1, 0, "wrap_one_cycle");
    end else begin
      expect_timeout("wrap_pulse");
    end

    // Asynchronous reset mid-run at 12.345.
    preload(12345);
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_lit(0, 0, 0, 0, "async_reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_lit(0, 0, 0, 0, "idle_after_reset");

    // Lap hold: snapshot at 00.050 while the live count runs on.
    press(1, 0);
    repeat (201) @(negedge clk);
    lap = 1'b1;
    repeat (3) @(negedge clk);
    expect_lit(50, 50, 1, 0, "lap_capture");
    repeat (320) @(negedge clk);
    expect_lit(50, 50, 1, 0, "lap_frozen");
    lap = 1'b0;
    repeat (3) @(negedge clk);
    expect_lit(130, 132, 1, 0, "lap_release");
    lap = 1'b1;
    repeat (4) @(negedge clk);
    press(0, 1);
    repeat (2) @(negedge clk);
    expect_lit(0, 0, 0, 0, "clear_in_hold");
    lap = 1'b0;

    // Randomized button, lap and preload activity, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      btn_ss  = ($urandom % 12) == 0;
      btn_clr = ($urandom % 80) == 0;
      if (($urandom % 40) == 0) lap = ~lap;
      if (($urandom % 400) == 0) preload(int'($urandom % 60000));
      if (i == 1500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    btn_ss = 1'b0; btn_clr = 1'b0; lap = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
